// File: rtl/answer_entry_if.sv
// ---------------------------------------------------------------------------
// answer_entry_if
// Bundles the signals between the game controller / keypad scanner side and
// the answer_entry block.
//   master modport (game controller + scanner side):
//     drives  state, key_valid, key_digit, expected
//     reads   value, digit_count, busy, result_valid, correct, timed_out
//   slave modport (answer_entry):
//     the mirror image of master.
// Parameter VAL_W sets the width of the entered and expected values.
// ---------------------------------------------------------------------------
interface answer_entry_if #(
  parameter int VAL_W = 10
);
  logic [3:0]       state;
  logic             key_valid;
  logic [3:0]       key_digit;
  logic [VAL_W-1:0] expected;
  logic [VAL_W-1:0] value;
  logic [2:0]       digit_count;
  logic             busy;
  logic             result_valid;
  logic             correct;
  logic             timed_out;

  modport master (
    output state, key_valid, key_digit, expected,
    input  value, digit_count, busy, result_valid, correct, timed_out
  );

  modport slave (
    input  state, key_valid, key_digit, expected,
    output value, digit_count, busy, result_valid, correct, timed_out
  );
endinterface

// File: rtl/answer_entry.sv
// ---------------------------------------------------------------------------
// answer_entry
// Assembles the player's multi-digit answer from keypad digit events while the
// game is in its answer-entry state, then compares it against the expected
// answer and reports a one-cycle verdict pulse.
//
// Ports:
//   clk  in   system clock, all logic on posedge
//   rst  in   synchronous active-high reset
//   bus  slave modport of answer_entry_if:
//        state/key_valid/key_digit/expected in,
//        value/digit_count/busy/result_valid/correct/timed_out out
//
// Parameters:
//   MAX_DIGITS   digits accepted before auto-submit (1..4)
//   VAL_W        value width, must hold 10^MAX_DIGITS-1
//   ENTRY_STATE  game state value that enables entry
//   TIMEOUT_CYC  idle cycles before a forced submit (TIMEOUT_EN only)
//
// Build option:
//   TIMEOUT_EN   when defined, an idle counter forces a submit after
//                TIMEOUT_CYC cycles without a key event; otherwise timed_out
//                is tied low and entry waits indefinitely.
// ---------------------------------------------------------------------------
module answer_entry #(
  parameter int MAX_DIGITS  = 3,
  parameter int VAL_W       = 10,
  parameter int ENTRY_STATE = 4,
  parameter int TIMEOUT_CYC = 500
) (
  input  logic          clk,
  input  logic          rst,
  answer_entry_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } fsm_t;

  fsm_t             fsm;
  logic             key_valid_q;
  logic [VAL_W-1:0] value;
  logic [2:0]       digit_count;
  logic             busy;
  logic             result_valid;
  logic             correct;

  logic             key_evt;
  logic             in_entry;
  logic             is_digit;
  logic             is_enter;
  logic [VAL_W-1:0] next_value;
  logic [2:0]       next_count;
  logic             count_full;

  // A held key produces exactly one event: only the rising edge of key_valid.
  assign key_evt    = bus.key_valid & ~key_valid_q;
  assign in_entry   = (bus.state == 4'(ENTRY_STATE));
  assign is_digit   = (bus.key_digit <= 4'd9);
  assign is_enter   = (bus.key_digit == 4'd10);
  // Decimal shift-in; the parameter rule on VAL_W guarantees no overflow.
  assign next_value = (value * VAL_W'(10)) + VAL_W'(bus.key_digit);
  assign next_count = digit_count + 3'd1;
  assign count_full = (next_count == 3'(MAX_DIGITS));

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          timed_out;
  logic          idle_expire;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle in COLLECT.
  assign idle_expire = (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign bus.timed_out = timed_out;
`else
  assign bus.timed_out = 1'b0;
`endif

  // Entry FSM with all outputs registered; abort outranks key events and
  // reset outranks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm          <= IDLE;
      key_valid_q  <= 1'b0;
      value        <= '0;
      digit_count  <= 3'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      correct      <= 1'b0;
`ifdef TIMEOUT_EN
      idle_cnt     <= '0;
      timed_out    <= 1'b0;
`endif
    end else begin
      key_valid_q  <= bus.key_valid;
      result_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          // value/correct from the previous answer stay visible until here.
          if (in_entry) begin
            fsm         <= COLLECT;
            busy        <= 1'b1;
            value       <= '0;
            digit_count <= 3'd0;
            correct     <= 1'b0;
`ifdef TIMEOUT_EN
            idle_cnt    <= '0;
            timed_out   <= 1'b0;
`endif
          end
        end
        COLLECT: begin
          if (!in_entry) begin
            fsm         <= IDLE;
            busy        <= 1'b0;
            value       <= '0;
            digit_count <= 3'd0;
          end else if (key_evt) begin
`ifdef TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (is_digit) begin
              value       <= next_value;
              digit_count <= next_count;
              if (count_full) begin
                fsm  <= CHECK;
                busy <= 1'b0;
              end
            end else if (is_enter && (digit_count != 3'd0)) begin
              fsm  <= CHECK;
              busy <= 1'b0;
            end
            // codes 11..15 and an empty enter are ignored
          end else begin
`ifdef TIMEOUT_EN
            if (idle_expire) begin
              fsm       <= CHECK;
              busy      <= 1'b0;
              timed_out <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
`endif
          end
        end
        CHECK: begin
          // expected is only looked at here.
          correct      <= (value == bus.expected);
          result_valid <= 1'b1;
          fsm          <= DONE;
        end
        DONE: begin
          if (!in_entry) begin
            fsm <= IDLE;
          end
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value        = value;
  assign bus.digit_count  = digit_count;
  assign bus.busy         = busy;
  assign bus.result_valid = result_valid;
  assign bus.correct      = correct;

endmodule

// File: tb/tb_answer_entry.sv
// ---------------------------------------------------------------------------
// tb_answer_entry
// Self-checking bench for answer_entry (MAX_DIGITS=3, VAL_W=10,
// ENTRY_STATE=4, TIMEOUT_CYC=500). Expected verdicts are queued when a submit
// is driven and checked by a monitor when result_valid appears.
// ---------------------------------------------------------------------------
module tb_answer_entry;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  answer_entry_if #(.VAL_W(10)) bus();

  answer_entry #(
    .MAX_DIGITS (3),
    .VAL_W      (10),
    .ENTRY_STATE(4),
    .TIMEOUT_CYC(500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [9:0] value;
    logic [2:0] count;
    logic       correct;
    logic       timed_out;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   pulses = 0;

  // Result monitor: sampled 1 time unit after the edge, pops the scoreboard.
  always begin
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    if (bus.result_valid === 1'b1) begin
      pulses++;
      got = {bus.value, bus.digit_count, bus.correct, bus.timed_out};
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got %h, required no result", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL verdict: got %h, required %h", got, e);
        end
      end
    end
  end

  task automatic press(input logic [3:0] d, input int hold);
    @(negedge clk);
    bus.key_digit = d;
    bus.key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    bus.key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_entry();
    @(negedge clk);
    bus.state = 4'd0;
    @(negedge clk);
    bus.state = 4'd4;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.value, bus.digit_count, bus.busy, bus.result_valid, bus.correct, bus.timed_out} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%0d c=%0d b=%b rv=%b ok=%b to=%b, required all 0",
               bus.value, bus.digit_count, bus.busy, bus.result_valid, bus.correct, bus.timed_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_enter_42();
    int p0;
    @(negedge clk);
    bus.state    = 4'd4;
    bus.expected = 10'd999;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.value !== 10'd0) begin
      n_bad++;
      $display("FAIL enter_collect: got busy=%b value=%0d, required busy=1 value=0", bus.busy, bus.value);
    end
    press(4'd4, 1);
    n_cmp++;
    if (bus.value !== 10'd4 || bus.digit_count !== 3'd1) begin
      n_bad++;
      $display("FAIL first_digit: got value=%0d cnt=%0d, required 4/1", bus.value, bus.digit_count);
    end
    press(4'd2, 1);
    n_cmp++;
    if (bus.value !== 10'd42 || bus.digit_count !== 3'd2) begin
      n_bad++;
      $display("FAIL second_digit: got value=%0d cnt=%0d, required 42/2", bus.value, bus.digit_count);
    end
    bus.expected = 10'd42;
    sb.push_back(exp_t'({10'd42, 3'd2, 1'b1, 1'b0}));
    p0 = pulses;
    press(4'd10, 1);
    n_cmp++;
    if (bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL enter_latency: got result_valid=%b, required 1 two clocks after enter", bus.result_valid);
    end
    bus.expected = 10'd0;
    @(negedge clk);
    n_cmp++;
    if (bus.result_valid !== 1'b0 || pulses !== p0 + 1) begin
      n_bad++;
      $display("FAIL pulse_width: got rv=%b pulses=%0d, required rv=0 pulses=%0d", bus.result_valid, pulses, p0 + 1);
    end
    bus.state = 4'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.value !== 10'd42 || bus.correct !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_in_idle: got value=%0d ok=%b busy=%b, required 42/1/0", bus.value, bus.correct, bus.busy);
    end
  endtask

  task automatic test_auto_submit();
    int p0;
    start_entry();
    bus.expected = 10'd124;
    press(4'd1, 1);
    press(4'd2, 1);
    sb.push_back(exp_t'({10'd123, 3'd3, 1'b0, 1'b0}));
    press(4'd3, 1);
    n_cmp++;
    if (bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL auto_submit_latency: got result_valid=%b, required 1", bus.result_valid);
    end
    @(negedge clk);
    p0 = pulses;
    press(4'd5, 1);
    press(4'd10, 1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.value !== 10'd123 || bus.digit_count !== 3'd3 || pulses !== p0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_ignores_keys: got value=%0d cnt=%0d pulses=%0d busy=%b, required 123/3/%0d/0",
               bus.value, bus.digit_count, pulses, bus.busy, p0);
    end
  endtask

  task automatic test_hold_and_ignore();
    int p0;
    start_entry();
    n_cmp++;
    if (bus.correct !== 1'b0 || bus.value !== 10'd0) begin
      n_bad++;
      $display("FAIL entry_clears: got ok=%b value=%0d, required 0/0", bus.correct, bus.value);
    end
    bus.expected = 10'd7;
    p0 = pulses;
    press(4'd10, 1);
    n_cmp++;
    if (bus.digit_count !== 3'd0 || bus.busy !== 1'b1 || pulses !== p0) begin
      n_bad++;
      $display("FAIL empty_enter: got cnt=%0d busy=%b pulses=%0d, required 0/1/%0d", bus.digit_count, bus.busy, pulses, p0);
    end
    press(4'd11, 1);
    press(4'd14, 1);
    n_cmp++;
    if (bus.digit_count !== 3'd0 || bus.value !== 10'd0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_codes: got cnt=%0d value=%0d busy=%b, required 0/0/1", bus.digit_count, bus.value, bus.busy);
    end
    press(4'd7, 20);
    n_cmp++;
    if (bus.value !== 10'd7 || bus.digit_count !== 3'd1) begin
      n_bad++;
      $display("FAIL held_key: got value=%0d cnt=%0d, required 7/1", bus.value, bus.digit_count);
    end
    sb.push_back(exp_t'({10'd7, 3'd1, 1'b1, 1'b0}));
    press(4'd10, 1);
    n_cmp++;
    if (bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_enter_latency: got result_valid=%b, required 1", bus.result_valid);
    end
  endtask

  task automatic test_abort();
    int p0;
    start_entry();
    n_cmp++;
    if (bus.correct !== 1'b0) begin
      n_bad++;
      $display("FAIL correct_cleared: got %b, required 0", bus.correct);
    end
    p0 = pulses;
    press(4'd9, 1);
    press(4'd8, 1);
    n_cmp++;
    if (bus.value !== 10'd98) begin
      n_bad++;
      $display("FAIL abort_pre: got value=%0d, required 98", bus.value);
    end
    // leave entry state in the same cycle as a new key edge
    @(negedge clk);
    bus.state     = 4'd2;
    bus.key_digit = 4'd8;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.value !== 10'd0 || bus.digit_count !== 3'd0) begin
      n_bad++;
      $display("FAIL abort: got busy=%b value=%0d cnt=%0d, required 0/0/0", bus.busy, bus.value, bus.digit_count);
    end
    @(negedge clk);
    bus.state = 4'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.value !== 10'd0 || bus.digit_count !== 3'd0 || pulses !== p0) begin
      n_bad++;
      $display("FAIL reentry: got busy=%b value=%0d cnt=%0d pulses=%0d, required 1/0/0/%0d",
               bus.busy, bus.value, bus.digit_count, pulses, p0);
    end
    bus.expected = 10'd3;
    press(4'd3, 1);
    sb.push_back(exp_t'({10'd3, 3'd1, 1'b1, 1'b0}));
    press(4'd10, 1);
    n_cmp++;
    if (bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reentry_result: got result_valid=%b, required 1", bus.result_valid);
    end
  endtask

  task automatic test_reset_mid();
    start_entry();
    press(4'd5, 1);
    press(4'd6, 1);
    n_cmp++;
    if (bus.value !== 10'd56 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: got value=%0d busy=%b, required 56/1", bus.value, bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.value, bus.digit_count, bus.busy, bus.result_valid, bus.correct, bus.timed_out} !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%0d c=%0d b=%b rv=%b ok=%b, required all 0",
               bus.value, bus.digit_count, bus.busy, bus.result_valid, bus.correct);
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int p0;
    int n;
    start_entry();
    bus.expected = 10'd5;
    press(4'd5, 1);
    p0 = pulses;
`ifdef TIMEOUT_EN
    sb.push_back(exp_t'({10'd5, 3'd1, 1'b1, 1'b1}));
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.result_valid !== 1'b1 || bus.timed_out !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout: got rv=%b to=%b after %0d cycles, required 1/1", bus.result_valid, bus.timed_out, n);
    end
`else
    n = 0;
    repeat (510) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.busy !== 1'b1 || pulses !== p0 || bus.timed_out !== 1'b0 || bus.value !== 10'd5) begin
      n_bad++;
      $display("FAIL no_timeout: got busy=%b pulses=%0d to=%b value=%0d after %0d cycles, required 1/%0d/0/5",
               bus.busy, pulses, bus.timed_out, bus.value, n, p0);
    end
`endif
  endtask

  initial begin
    rst           = 1'b1;
    bus.state     = 4'd0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd11;
    bus.expected  = 10'd0;
    test_reset();
    test_enter_42();
    test_auto_submit();
    test_hold_and_ignore();
    test_abort();
    test_reset_mid();
    test_timeout();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
